vectorial_register_file: RTL and testbench

VECTORIAL_REGISTER_FILE -- requirements
Module: vectorial_register_file

---
 rtl/vectorial_register_file_pkg.sv | 16 +
 rtl/vrf_read_port.sv | 29 ++
 rtl/vectorial_register_file.sv | 69 ++++++
 tb/tb_vectorial_register_file.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/vectorial_register_file_pkg.sv
// Shared defaults and types for the vector register file.
// Holds the default geometry, the address-width derivation and the vector word type.
package vectorial_register_file_pkg;

  localparam int VRF_DEPTH  = 16;
  localparam int VRF_BITS   = 128;
  localparam int VRF_ADDR_W = $clog2(VRF_DEPTH);

  typedef logic [VRF_BITS-1:0] vec_word_t;

  // Address width for any power-of-two depth of at least 2.
  function automatic int vrf_addr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/vrf_read_port.sv
// One combinational read port of the vector register file.
// Selects a stored register, overridden by the in-flight write to the same index.
module vrf_read_port
  import vectorial_register_file_pkg::*;
#(
  parameter int DEPTH  = VRF_DEPTH,
  parameter int BITS   = VRF_BITS,
  parameter int ADDR_W = vrf_addr_width(DEPTH)
) (
  input  logic                        rst,
  input  logic [ADDR_W-1:0]           address,
  input  logic [ADDR_W-1:0]           addressw,
  input  logic [BITS-1:0]             writeData,
  input  logic                        writeEn,
  input  logic [DEPTH-1:0][BITS-1:0]  regs,
  output logic [BITS-1:0]             read_data
);

  // Reset forces zero and suppresses the bypass; otherwise a matching write wins.
  always_comb begin
    read_data = regs[address];
    if (rst) begin
      read_data = '0;
    end else if (writeEn && (address == addressw)) begin
      read_data = writeData;
    end
  end

endmodule

// File: rtl/vectorial_register_file.sv
// Flip-flop based vector register file: DEPTH x BITS, one write port and two
// combinational read ports with write-through bypass.
module vectorial_register_file
  import vectorial_register_file_pkg::*;
#(
  parameter int DEPTH = VRF_DEPTH,
  parameter int BITS  = VRF_BITS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [vrf_addr_width(DEPTH)-1:0]  address1,
  input  logic [vrf_addr_width(DEPTH)-1:0]  address2,
  input  logic [vrf_addr_width(DEPTH)-1:0]  addressw,
  input  logic [BITS-1:0]                   writeData,
  input  logic                              writeEn,
  output logic [BITS-1:0]                   read1,
  output logic [BITS-1:0]                   read2
);

  localparam int ADDR_W = vrf_addr_width(DEPTH);

  logic [DEPTH-1:0][BITS-1:0] regs_q;
  logic [DEPTH-1:0][BITS-1:0] regs_d;

  always_comb begin
    regs_d = regs_q;
    if (writeEn) begin
      regs_d[addressw] = writeData;
    end
  end

  // Reset clears every register at once, so writes during reset have no effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  vrf_read_port #(
    .DEPTH (DEPTH),
    .BITS  (BITS),
    .ADDR_W(ADDR_W)
  ) u_read_port1 (
    .rst      (rst),
    .address  (address1),
    .addressw (addressw),
    .writeData(writeData),
    .writeEn  (writeEn),
    .regs     (regs_q),
    .read_data(read1)
  );

  vrf_read_port #(
    .DEPTH (DEPTH),
    .BITS  (BITS),
    .ADDR_W(ADDR_W)
  ) u_read_port2 (
    .rst      (rst),
    .address  (address2),
    .addressw (addressw),
    .writeData(writeData),
    .writeEn  (writeEn),
    .regs     (regs_q),
    .read_data(read2)
  );

endmodule

// File: tb/tb_vectorial_register_file.sv
// Directed self-checking bench for vectorial_register_file (DEPTH=16, BITS=32),
// with expected read values queued as a scoreboard and compared after settling.
module tb_vectorial_register_file;

  localparam int DEPTH  = 16;
  localparam int BITS   = 32;
  localparam int ADDR_W = 4;

  typedef struct {
    string           tag;
    int              port;
    logic [BITS-1:0] value;
  } expect_t;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] address1;
  logic [ADDR_W-1:0] address2;
  logic [ADDR_W-1:0] addressw;
  logic [BITS-1:0]   writeData;
  logic              writeEn;
  logic [BITS-1:0]   read1;
  logic [BITS-1:0]   read2;

  expect_t scoreboard[$];
  int      checks;
  int      errors;

  vectorial_register_file #(
    .DEPTH(DEPTH),
    .BITS (BITS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .address1 (address1),
    .address2 (address2),
    .addressw (addressw),
    .writeData(writeData),
    .writeEn  (writeEn),
    .read1    (read1),
    .read2    (read2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2,
                               input logic we, input logic [ADDR_W-1:0] aw,
                               input logic [BITS-1:0] wd);
    address1  = a1;
    address2  = a2;
    writeEn   = we;
    addressw  = aw;
    writeData = wd;
  endtask

  task automatic expectRead(input string tag, input int port, input logic [BITS-1:0] value);
    expect_t e;
    e.tag   = tag;
    e.port  = port;
    e.value = value;
    scoreboard.push_back(e);
  endtask

  // Lets the combinational outputs settle, then drains the scoreboard.
  task automatic checkOutput();
    expect_t         e;
    logic [BITS-1:0] observed;
    #1;
    while (scoreboard.size() > 0) begin
      e = scoreboard.pop_front();
      observed = (e.port == 1) ? read1 : read2;
      checks++;
      assert (observed === e.value) else begin
        errors++;
        $error("[TB] FAIL %s: observed %h expected %h", e.tag, observed, e.value);
      end
    end
  endtask

  task automatic writeReg(input logic [ADDR_W-1:0] aw, input logic [BITS-1:0] wd);
    @(negedge clk);
    applyStimulus(address1, address2, 1'b1, aw, wd);
    @(posedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    applyStimulus(4'd0, 4'd15, 1'b0, 4'd0, '0);

    expectRead("reset_read1", 1, 32'h0);
    expectRead("reset_read2", 2, 32'h0);
    checkOutput();

    @(negedge clk);
    rst = 1'b0;

    writeReg(4'd10, 32'hAAAAAAAA);
    writeReg(4'd1,  32'hBBBBBBBB);
    writeReg(4'd5,  32'hCCCCCCCC);
    writeReg(4'd6,  32'hDDDDDDDD);
    writeReg(4'd12, 32'hEEEEEEEE);
    @(negedge clk);
    applyStimulus(4'd1, 4'd10, 1'b0, 4'd12, 32'hEEEEEEEE);
    expectRead("rd_reg1", 1, 32'hBBBBBBBB);
    expectRead("rd_reg10", 2, 32'hAAAAAAAA);
    checkOutput();

    applyStimulus(4'd5, 4'd12, 1'b0, 4'd12, 32'hEEEEEEEE);
    expectRead("rd_reg5", 1, 32'hCCCCCCCC);
    expectRead("rd_reg12", 2, 32'hEEEEEEEE);
    checkOutput();

    applyStimulus(4'd12, 4'd12, 1'b0, 4'd12, 32'hEEEEEEEE);
    expectRead("same_idx_read1", 1, 32'hEEEEEEEE);
    expectRead("same_idx_read2", 2, 32'hEEEEEEEE);
    checkOutput();

    applyStimulus(4'd6, 4'd6, 1'b0, 4'd6, 32'h12345678);
    repeat (3) @(posedge clk);
    @(negedge clk);
    expectRead("no_write_reg6_p1", 1, 32'hDDDDDDDD);
    expectRead("no_write_reg6_p2", 2, 32'hDDDDDDDD);
    checkOutput();

    applyStimulus(4'd3, 4'd3, 1'b1, 4'd3, 32'h5A5A5A5A);
    expectRead("bypass_read1", 1, 32'h5A5A5A5A);
    expectRead("bypass_read2", 2, 32'h5A5A5A5A);
    checkOutput();

    applyStimulus(4'd3, 4'd10, 1'b1, 4'd3, 32'h5A5A5A5A);
    expectRead("bypass_read1_again", 1, 32'h5A5A5A5A);
    expectRead("old_value_other_idx", 2, 32'hAAAAAAAA);
    checkOutput();
    @(posedge clk);
    @(negedge clk);
    applyStimulus(4'd3, 4'd15, 1'b0, 4'd3, 32'h0);
    expectRead("stored_reg3", 1, 32'h5A5A5A5A);
    expectRead("unwritten_reg15", 2, 32'h0);
    checkOutput();

    applyStimulus(4'd15, 4'd0, 1'b1, 4'd15, 32'h77777777);
    expectRead("bypass_top_idx", 1, 32'h77777777);
    checkOutput();
    @(posedge clk);
    @(negedge clk);
    applyStimulus(4'd15, 4'd0, 1'b0, 4'd0, 32'h0);
    expectRead("stored_top_idx", 1, 32'h77777777);
    checkOutput();

    // Mid-cycle reset with a live write request that must be ignored and not bypassed.
    #2;
    applyStimulus(4'd7, 4'd7, 1'b1, 4'd7, 32'hFFFFFFFF);
    rst = 1'b1;
    expectRead("rst_bypass_off_p1", 1, 32'h0);
    expectRead("rst_bypass_off_p2", 2, 32'h0);
    checkOutput();
    for (int i = 0; i < DEPTH; i++) begin
      address1 = ADDR_W'(i);
      address2 = ADDR_W'(DEPTH - 1 - i);
      expectRead($sformatf("rst_clear_p1_idx%0d", i), 1, 32'h0);
      expectRead($sformatf("rst_clear_p2_idx%0d", DEPTH - 1 - i), 2, 32'h0);
      checkOutput();
    end

    @(negedge clk);
    applyStimulus(4'd7, 4'd10, 1'b0, 4'd0, 32'h0);
    rst = 1'b0;
    expectRead("post_rst_reg7", 1, 32'h0);
    expectRead("post_rst_reg10", 2, 32'h0);
    checkOutput();

    writeReg(4'd15, 32'h00000001);
    @(negedge clk);
    applyStimulus(4'd15, 4'd10, 1'b0, 4'd0, 32'h0);
    expectRead("post_rst_write_reg15", 1, 32'h00000001);
    expectRead("post_rst_reg10_still0", 2, 32'h0);
    checkOutput();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
